axis_pixel_packer: RTL

//  Upstream feeder for the TCB classifier AXI4-Stream wrapper. Accepts one 8-bit pixel per beat,

---
 rtl/axis_pack_pkg.sv | 16 +
 rtl/pixel_lane_assembler.sv | 38 +++
 rtl/axis_pixel_packer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axis_pack_pkg.sv
// Shared types and sizing helpers for the AXI-Stream pixel packer.
package axis_pack_pkg;
  typedef enum logic [1:0] {IDLE, FILL, PAD, DRAIN} state_t;

  localparam int LANES              = 4;
  localparam int PIXELS_PER_FRAME_D = 121;
  localparam int WORDS_PER_FRAME    = (PIXELS_PER_FRAME_D + LANES - 1) / LANES;

  // Bits needed to count 0..v-1; never returns zero width.
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/pixel_lane_assembler.sv
// Collects pixels into a word lane by lane; word_done fires on the beat that completes it.
module pixel_lane_assembler
  import axis_pack_pkg::*;
#(
  parameter int PIX_WIDTH = 8,
  parameter int NUM_LANES = 4
) (
  input  logic                                axi_clk,
  input  logic                                axi_reset,
  input  logic [PIX_WIDTH-1:0]                pix,
  input  logic                                wr,
  input  logic                                flush,
  output logic [NUM_LANES-1:0][PIX_WIDTH-1:0] word,
  output logic                                word_done
);
  localparam int            LW        = clogb2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  logic [LW-1:0]                       lane_q;
  logic [NUM_LANES-1:0][PIX_WIDTH-1:0] pix_q;

  // word already includes the beat being written, so the top can register it directly.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign word[g] = (wr && lane_q == LW'(g)) ? pix : pix_q[g];
  end

  assign word_done = wr && (flush || lane_q == LAST_LANE);

  always_ff @(posedge axi_clk) begin
    if (axi_reset || word_done) begin
      pix_q  <= '0;
      lane_q <= '0;
    end else if (wr) begin
      pix_q  <= word;
      lane_q <= lane_q + LW'(1);
    end
  end
endmodule

// File: rtl/axis_pixel_packer.sv
// Packs 8-bit pixels into fixed-length frames of 32-bit AXI-Stream words, zero-padding short frames.
// Define PACK_BINARIZE_EN to threshold each pixel to 8'hFF / 8'h00 before packing.
module axis_pixel_packer
  import axis_pack_pkg::*;
#(
  parameter int PIX_WIDTH        = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int PIXELS_PER_FRAME = 121,
  parameter int THRESHOLD        = 128
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  s_axis_valid,
  input  logic [PIX_WIDTH-1:0]  s_axis_data,
  input  logic                  s_axis_last,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  frame_err
);
  localparam int NUM_LANES = DATA_WIDTH / PIX_WIDTH;
  localparam int WPF       = (PIXELS_PER_FRAME + NUM_LANES - 1) / NUM_LANES;
  localparam int PW        = clogb2(PIXELS_PER_FRAME);
  localparam int WW        = clogb2(WPF);

  localparam logic [PW-1:0]        PIX_LAST  = PW'(PIXELS_PER_FRAME - 1);
  localparam logic [WW-1:0]        WORD_LAST = WW'(WPF - 1);
  localparam logic [PIX_WIDTH-1:0] THR       = PIX_WIDTH'(THRESHOLD);

`ifdef PACK_BINARIZE_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  state_t                              state_q, state_d;
  logic [PW-1:0]                       pix_cnt;
  logic [WW-1:0]                       word_cnt;
  logic                                slot_free, acc, frame_end, word_done;
  logic                                load_pad, err_d, clr_cnt;
  logic [PIX_WIDTH-1:0]                pix_in;
  logic [NUM_LANES-1:0][PIX_WIDTH-1:0] asm_word;

  assign slot_free = !m_axis_valid || m_axis_ready;

  always_comb begin
    pix_in = s_axis_data;
    if (BIN_EN) pix_in = (s_axis_data >= THR) ? '1 : '0;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    s_axis_ready = 1'b0;
    acc          = 1'b0;
    frame_end    = 1'b0;
    load_pad     = 1'b0;
    err_d        = 1'b0;
    clr_cnt      = 1'b0;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        s_axis_ready = slot_free;
        acc          = s_axis_valid && slot_free;
        frame_end    = acc && (s_axis_last || pix_cnt == PIX_LAST);
        if (frame_end) begin
          if (word_cnt == WORD_LAST) state_d = DRAIN;
          else begin
            state_d = PAD;
            err_d   = 1'b1;
          end
        end
      end
      PAD: begin
        if (slot_free) begin
          load_pad = 1'b1;
          if (word_cnt == WORD_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_axis_valid && m_axis_ready && m_axis_last) begin
          state_d = FILL;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pixel_lane_assembler #(
    .PIX_WIDTH (PIX_WIDTH),
    .NUM_LANES (NUM_LANES)
  ) u_asm (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .pix       (pix_in),
    .wr        (acc),
    .flush     (frame_end),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_ff @(posedge axi_clk) begin
    if (axi_reset || clr_cnt) begin
      pix_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      if (acc)                   pix_cnt  <= frame_end ? '0 : pix_cnt + PW'(1);
      if (word_done || load_pad) word_cnt <= word_cnt + WW'(1);
    end
  end

  // Single-entry output slot: a new word only loads when the slot is free or draining this cycle.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_data  <= '0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= err_d;
      if (word_done || load_pad) begin
        m_axis_valid <= 1'b1;
        m_axis_last  <= (word_cnt == WORD_LAST);
        m_axis_data  <= load_pad ? '0 : asm_word;
      end else if (m_axis_ready) begin
        m_axis_valid <= 1'b0;
        m_axis_last  <= 1'b0;
      end
    end
  end
endmodule
